r_num_ctrl: RTL and testbench
=============================

Name: r_num_ctrl

Overview:
Write controller for the 3-bit record-number register in the health monitor datapath. Arbitrates between three requesters: host direct load, up/down buttons, and an auto-scan sequencer. Issues single-cycle enable/data writes to the register. Keeps a mirror of the current number for the display and status logic.

Parameters:
NUM_MAX, 7, highest legal record number (1..7); values above it are never written
HOLD_TICKS, 4, scan ticks that auto-scan stays paused after any manual/host write (1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
host_req  input  1  host load request, level; sampled each cycle
host_num  input  3  host-requested record number
host_gnt  output  1  one-cycle pulse, host write issued this cycle
btn_up  input  1  debounced single-cycle pulse, increment
btn_dn  input  1  debounced single-cycle pulse, decrement
scan_mode  input  1  1 = auto-scan enabled
tick  input  1  single-cycle scan-rate strobe
reg_en  output  1  write enable to the record-number register
reg_d  output  3  write data to the record-number register
cur_num  output  3  mirror of last written number
scan_hold  output  1  1 while state is HOLD

Behaviour:
- Reset (async, rst_n=0): state IDLE, cur_num=0, reg_d=0, reg_en=0, host_gnt=0, hold counter=0, scan_hold=0. No write is issued on reset release.
- All outputs registered. Request sampled in cycle n -> reg_en=1, reg_d, cur_num updated in cycle n+1. Register captures on the edge ending n+1. reg_en is high exactly one cycle per write.
- Per-cycle priority: host_req > button event > scan tick. At most one write per cycle. Losing requests are dropped, not queued. Exception: host_req is level and stays pending.
- Host: new = min(host_num, NUM_MAX). host_gnt pulses with the same reg_en. A held host_req writes every cycle; the host drops req after gnt.
- Buttons: btn_up and btn_dn in the same cycle cancel each other; no write.
  - up: cur_num==NUM_MAX -> 0, else +1.
  - dn: cur_num==0 -> NUM_MAX, else -1.
- Scan: a tick in state SCAN writes the next number, wrapping NUM_MAX -> 0.
- A host or button write always issues regardless of state. If scan_mode=1, it also loads hold counter = HOLD_TICKS and moves to HOLD; this also reloads when already in HOLD.
- FSM:
  - IDLE: scan_mode=1 -> SCAN.
  - SCAN: scan_mode=0 -> IDLE. Manual/host write -> HOLD.
  - HOLD: each tick decrements the counter, with no write. Counter reaches 0 -> SCAN; the first scan write happens on the next tick after that. scan_mode=0 -> IDLE, counter cleared.
- Tick in the same cycle as a winning manual/host write: the tick is ignored and does not decrement.
- tick has no effect in IDLE.
- Reset mid-HOLD or mid-write: everything returns to reset values immediately. A reg_en in flight is deasserted.

Optional Feature:
R_NUM_SAT_EN:
- Defined: buttons saturate. up at NUM_MAX and dn at 0 issue no write, and no hold reload is performed.
- Undefined: buttons wrap as described above.
- Scan always wraps in both builds.

Test Plan:
1. Reset release, idle 10 cycles -> reg_en never asserted, cur_num=0, host_gnt=0.
2. host_req=1 with host_num=5 for one cycle -> next cycle reg_en=1, reg_d=5, host_gnt=1, cur_num=5. Then host_num=7 with NUM_MAX=6 -> reg_d=6.
3. cur_num=7, btn_up -> reg_d=0 (wrap). btn_dn at 0 -> reg_d=7. btn_up+btn_dn together -> no reg_en. With R_NUM_SAT_EN: up at 7 and dn at 0 -> no reg_en.
4. scan_mode=1, 10 ticks from cur_num=3 -> writes 4,5,6,7,0,1,2,3,4,5, one reg_en per tick.
5. During scan, btn_up at cur_num=2 -> write 3, scan_hold=1. Next 4 ticks produce no writes. 5th tick writes 4, scan_hold=0.
6. host_req and btn_up and tick in the same cycle -> only the host write is issued, host_gnt=1. Then rst_n pulsed low mid-HOLD -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/r_num_ctrl.sv
// Write controller for the 3-bit record-number register: host > button > scan-tick arbitration.
// Build option R_NUM_SAT_EN: buttons saturate at 0 / NUM_MAX instead of wrapping.
module r_num_ctrl #(
  parameter int NUM_MAX    = 7,
  parameter int HOLD_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_req,
  input  logic [2:0] host_num,
  output logic       host_gnt,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       scan_mode,
  input  logic       tick,
  output logic       reg_en,
  output logic [2:0] reg_d,
  output logic [2:0] cur_num,
  output logic       scan_hold
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD} state_t;

  localparam logic [2:0] LP_MAX  = 3'(NUM_MAX);
  localparam logic [7:0] LP_HOLD = 8'(HOLD_TICKS);

  state_t     r_state, w_nstate;
  logic [7:0] r_cnt, w_ncnt;
  logic       r_en, r_gnt, r_hold;
  logic [2:0] r_d, r_cur;

  logic       w_wr, w_gnt, w_man, w_btn_ok;
  logic [2:0] w_d, w_btn_d, w_host_d, w_inc, w_dec;
  logic       w_up_only, w_dn_only;

  assign w_up_only = btn_up & ~btn_dn;
  assign w_dn_only = btn_dn & ~btn_up;
  assign w_inc     = (r_cur == LP_MAX) ? 3'd0 : 3'(r_cur + 3'd1);
  assign w_dec     = (r_cur == 3'd0) ? LP_MAX : 3'(r_cur - 3'd1);
  assign w_host_d  = (host_num > LP_MAX) ? LP_MAX : host_num;

  always_comb begin
    w_btn_d  = r_cur;
    w_btn_ok = 1'b0;
    if (w_up_only) begin
      w_btn_d = w_inc;
`ifdef R_NUM_SAT_EN
      w_btn_ok = (r_cur != LP_MAX);
`else
      w_btn_ok = 1'b1;
`endif
    end else if (w_dn_only) begin
      w_btn_d = w_dec;
`ifdef R_NUM_SAT_EN
      w_btn_ok = (r_cur != 3'd0);
`else
      w_btn_ok = 1'b1;
`endif
    end
  end

  // A manual/host write suppresses the tick entirely, including the hold decrement.
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_wr     = 1'b0;
    w_d      = r_d;
    w_gnt    = 1'b0;
    w_man    = 1'b0;
    if (host_req) begin
      w_wr  = 1'b1;
      w_d   = w_host_d;
      w_gnt = 1'b1;
      w_man = 1'b1;
    end else if (w_btn_ok) begin
      w_wr  = 1'b1;
      w_d   = w_btn_d;
      w_man = 1'b1;
    end
    case (r_state)
      S_IDLE: if (scan_mode) w_nstate = S_SCAN;
      S_SCAN: begin
        if (!scan_mode) w_nstate = S_IDLE;
        else if (tick && !w_man) begin
          w_wr = 1'b1;
          w_d  = w_inc;
        end
      end
      S_HOLD: begin
        if (!scan_mode) begin
          w_nstate = S_IDLE;
          w_ncnt   = 8'd0;
        end else if (tick && !w_man) begin
          w_ncnt = r_cnt - 8'd1;
          if (r_cnt == 8'd1) w_nstate = S_SCAN;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
    if (w_man && scan_mode) begin
      w_nstate = S_HOLD;
      w_ncnt   = LP_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_en    <= 1'b0;
      r_gnt   <= 1'b0;
      r_hold  <= 1'b0;
      r_d     <= 3'd0;
      r_cur   <= 3'd0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_en    <= w_wr;
      r_gnt   <= w_gnt;
      r_hold  <= (w_nstate == S_HOLD);
      if (w_wr) begin
        r_d   <= w_d;
        r_cur <= w_d;
      end
    end
  end

  assign reg_en    = r_en;
  assign reg_d     = r_d;
  assign host_gnt  = r_gnt;
  assign cur_num   = r_cur;
  assign scan_hold = r_hold;

endmodule

// File: tb/tb_r_num_ctrl.sv
// Scoreboard bench for r_num_ctrl: a behavioural model predicts writes and hold status,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_r_num_ctrl;
  localparam int NM = 6;
  localparam int HT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_req = 1'b0;
  logic [2:0] host_num = 3'd0;
  logic       btn_up = 1'b0, btn_dn = 1'b0, scan_mode = 1'b0, tick = 1'b0;
  logic       host_gnt, reg_en, scan_hold;
  logic [2:0] reg_d, cur_num;

  r_num_ctrl #(.NUM_MAX(NM), .HOLD_TICKS(HT)) dut (
    .clk(clk), .rst_n(rst_n), .host_req(host_req), .host_num(host_num),
    .host_gnt(host_gnt), .btn_up(btn_up), .btn_dn(btn_dn), .scan_mode(scan_mode),
    .tick(tick), .reg_en(reg_en), .reg_d(reg_d), .cur_num(cur_num), .scan_hold(scan_hold)
  );

  always #5 clk = ~clk;

  typedef struct {int stamp; int d; int gnt; int cur; int hold;} exp_t;
  exp_t wq[$];
  exp_t sq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit in_reset = 1'b1;
  bit started = 1'b0;

  // Model state: current number, whether scan was enabled last cycle, paused ticks left
  int m_cur = 0;
  int m_prev_mode = 0;
  int m_rem = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (started && !in_reset) begin
      exp_t e;
      if (sq.size() > 0 && sq[0].stamp == cyc) begin
        e = sq.pop_front();
        chk("cur_num", int'(cur_num), e.cur);
        chk("scan_hold", int'(scan_hold), e.hold);
      end
      if (reg_en) begin
        if (wq.size() == 0 || wq[0].stamp != cyc) chk("unexpected_reg_en", int'(reg_en), 0);
        else begin
          e = wq.pop_front();
          chk("reg_d", int'(reg_d), e.d);
          chk("host_gnt", int'(host_gnt), e.gnt);
        end
      end else begin
        chk("gnt_without_write", int'(host_gnt), 0);
        if (wq.size() > 0 && wq[0].stamp == cyc) begin
          chk("missing_reg_en", int'(reg_en), 1);
          void'(wq.pop_front());
        end
      end
    end
  end

  function automatic int wrap_up(input int v);
    return (v == NM) ? 0 : v + 1;
  endfunction

  task automatic step(input bit hr, input int hn, input bit up, input bit dn,
                      input bit sm, input bit tk);
    bit wr, gnt, man, blocked;
    int d;
    exp_t e;
    @(negedge clk);
    host_req = hr; host_num = 3'(hn); btn_up = up; btn_dn = dn; scan_mode = sm; tick = tk;
    wr = 0; gnt = 0; man = 0; d = 0;
    if (hr) begin
      wr = 1; gnt = 1; man = 1; d = (hn > NM) ? NM : hn;
    end else if (up != dn) begin
      d = up ? wrap_up(m_cur) : ((m_cur == 0) ? NM : m_cur - 1);
`ifdef R_NUM_SAT_EN
      blocked = up ? (m_cur == NM) : (m_cur == 0);
`else
      blocked = 0;
`endif
      if (!blocked) begin wr = 1; man = 1; end
    end
    if (!man && tk && m_prev_mode == 1 && sm) begin
      if (m_rem == 0) begin wr = 1; d = wrap_up(m_cur); end
      else m_rem--;
    end
    if (!sm) m_rem = 0;
    else if (man) m_rem = HT;
    m_prev_mode = sm;
    if (wr) m_cur = d;
    e.stamp = cyc + 1; e.d = d; e.gnt = gnt; e.cur = m_cur; e.hold = (m_rem > 0);
    sq.push_back(e);
    if (wr) wq.push_back(e);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    in_reset = 1'b1;
    rst_n = 1'b0;
    host_req = 0; btn_up = 0; btn_dn = 0; scan_mode = 0; tick = 0;
    #1;
    chk("rst_reg_en", int'(reg_en), 0);
    chk("rst_reg_d", int'(reg_d), 0);
    chk("rst_cur_num", int'(cur_num), 0);
    chk("rst_host_gnt", int'(host_gnt), 0);
    chk("rst_scan_hold", int'(scan_hold), 0);
    wq.delete(); sq.delete();
    m_cur = 0; m_prev_mode = 0; m_rem = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    in_reset = 1'b0;
  endtask

  initial begin
    int hr_left;
    int hn;
    bit sm;
    repeat (3) @(negedge clk);
    chk("init_reg_en", int'(reg_en), 0);
    chk("init_cur_num", int'(cur_num), 0);
    rst_n = 1'b1;
    in_reset = 1'b0;
    started = 1'b1;

    // 1: idle after reset
    repeat (10) step(0, 0, 0, 0, 0, 0);
    // 2: host load and clamp
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 7, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // 3: button wrap / cancel at both ends
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    // 4: scan from 3, ten ticks
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1, 0);
    end
    // 5: button during scan pauses for HT ticks
    step(1, 2, 0, 0, 1, 0);
    for (int i = 0; i < HT + 1; i++) step(0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 1, 0);
    for (int i = 0; i < HT + 2; i++) begin
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1, 0);
    end
    // 6: host beats button and tick; then reset mid-HOLD and mid-write
    step(1, 1, 1, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    async_reset();
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(1, 4, 0, 0, 0, 0);
    async_reset();
    repeat (3) step(0, 0, 0, 0, 0, 0);

    // Randomized traffic
    hr_left = 0; hn = 0; sm = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hr_left == 0 && $urandom_range(0, 99) < 5) begin
        hr_left = $urandom_range(1, 3);
        hn = $urandom_range(0, 7);
      end
      if ($urandom_range(0, 99) < 3) sm = ~sm;
      step(hr_left > 0, hn, $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12,
           sm, $urandom_range(0, 99) < 35);
      if (hr_left > 0) hr_left--;
    end
    repeat (3) step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("writes_left_in_queue", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
